// File: rtl/audio_pkg.sv
// Shared types and constants for the audio output path.
// Sample width, sample type and the write-buffer FSM state encoding.
package audio_pkg;

    localparam int SAMPLE_W = 24;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } wbuf_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Circular sample store with exact occupancy count; push at full is dropped unless a pop
// happens in the same cycle. Head is visible one edge after the push. No backpressure: drops are flagged.
module sample_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       overflow_evt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A pop frees a slot in the same cycle, so a push at full still lands.
    assign do_pop         = pop_i && !empty_o;
    assign do_push        = push_i && (!full_o || do_pop);
    assign overflow_evt_o = push_i && !do_push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/audio_write_buffer.sv
// Buffers filtered samples and feeds the codec write handshake after priming to half full.
// Latency: push at edge k presented at edge k+1 in RUN; write_ready low simply holds samples (overflow drops flagged).
module audio_write_buffer
    import audio_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       write_ready,
    output logic                       write,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       underrun,
    output logic                       overflow
);

    localparam int                CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] PRIME_LVL = CNT_W'(DEPTH / 2);

    wbuf_state_t      state_q, state_d;
    logic             write_q, write_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             underrun_q, underrun_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] head;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] prime_count;
    logic             full, empty, overflow_evt;
    logic             issue, pop;

    sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk            (clk),
        .reset          (reset),
        .push_i         (wr_en),
        .data_i         (data_in),
        .pop_i          (pop),
        .head_o         (head),
        .count_o        (fifo_count),
        .full_o         (full),
        .empty_o        (empty),
        .overflow_evt_o (overflow_evt)
    );

    // Gating on the registered strobe keeps write from ever being high two cycles running.
    assign issue = (state_q == RUN) && write_ready && !write_q;
    assign pop   = issue && !empty;

    // PRIME never pops, so the post-edge count is just the current count plus an accepted push.
    assign prime_count = fifo_count + CNT_W'(wr_en && !full);

    always_comb begin
        state_d    = state_q;
        write_d    = 1'b0;
        data_out_d = data_out_q;
        last_d     = last_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q | overflow_evt;
        case (state_q)
            PRIME: begin
                if (prime_count >= PRIME_LVL) state_d = RUN;
            end
            RUN: begin
                if (issue) begin
                    write_d = 1'b1;
                    if (!empty) begin
                        data_out_d = head;
                        last_d     = head;
                    end else begin
                        data_out_d = last_q;
                        underrun_d = 1'b1;
                    end
                end
            end
            default: state_d = PRIME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= PRIME;
            write_q    <= 1'b0;
            data_out_q <= '0;
            last_q     <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            data_out_q <= data_out_d;
            last_q     <= last_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    assign write    = write_q;
    assign data_out = data_out_q;
    assign count    = fifo_count;
    assign underrun = underrun_q;
    assign overflow = overflow_q;

endmodule

// File: doc/audio_write_buffer.md
# audio_write_buffer

Output-side sample buffer for the audio path: accepts filtered 24-bit samples from the filter stage (one per `wr_en` strobe) and hands them to the codec write interface using its `write_ready`/`write` handshake. It is the write-direction counterpart of the filter's `read`-strobed input. It absorbs rate jitter between filter output and codec demand, primes before first playback, and covers underrun and overflow deterministically.

## Interface
- `WIDTH`, 24, sample width in bits (two's complement).
- `DEPTH`, 8, FIFO depth in samples; power of two, ≥4.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low; state cleared on any rising edge of `clk` with `reset`=0.
- `wr_en`  in  1  one-cycle strobe: `data_in` is a valid filtered sample.
- `data_in`  in  WIDTH  sample from filter.
- `write_ready`  in  1  codec can accept a sample.
- `write`  out  1  registered one-cycle strobe: codec takes `data_out`.
- `data_out`  out  WIDTH  registered sample to codec.
- `count`  out  $clog2(DEPTH)+1  samples currently stored.
- `underrun`  out  1  sticky: a write was issued from an empty FIFO.
- `overflow`  out  1  sticky: a sample was dropped because the FIFO was full.

## Operation
- Reset values: `write`=0, `data_out`=0, `count`=0, `underrun`=0, `overflow`=0, state=PRIME, internal last-sample register=0, pointers=0.
- FIFO: circular buffer, read/write pointers wrap modulo DEPTH; `count` is exact and never exceeds DEPTH.
- Push: `wr_en`=1 and (not full, or pop in same cycle) → store `data_in`, advance write pointer.
- Push while full with no pop in the same cycle → sample dropped, contents unchanged, `overflow` set.
- FSM states:
  - PRIME: `write` held 0, no pops. Go to RUN on the edge where the updated `count` ≥ DEPTH/2.
  - RUN: issue logic active. Never returns to PRIME except via reset.
- Issue rule in RUN, evaluated each edge: issue = `write_ready` && !`write` (current registered value). This guarantees that `write` is never high on two consecutive cycles.
- On issue with FIFO non-empty: `data_out` ← head, pop, and last-sample ← head.
- On issue with FIFO empty: `data_out` ← last-sample (repeat), no pop, `underrun` set.
  - A push arriving in the same cycle is not bypassed; it is stored normally.
- No issue → `write`=0 next cycle; `data_out` keeps its value.
- Simultaneous push and pop: both take effect; `count` unchanged; legal at full and at empty+1.
- Sticky flags clear only on reset.
- Arithmetic: none on sample data. Samples pass bit-exact, with no sign change or truncation.

## Timing
- `write` and `data_out` are registered; they change only on clock edges.
- Push-to-store: a sample strobed at edge k is readable from edge k+1.
- In RUN with `write_ready` high and `write` low, a sample pushed at edge k appears with `write`=1 after edge k+1 (one-cycle latency).
- Maximum throughput: one sample every 2 cycles while `write_ready` stays high.
- The first `write` occurs one edge after PRIME→RUN, provided `write_ready`=1.
- `write_ready` falling while `write`=1: the transfer already presented still counts; the codec latches it that cycle.
- Reset mid-operation: all stored samples are discarded, outputs return to reset values at that edge, and PRIME restarts.

## Structure
- Shared package `audio_pkg`:
  - `SAMPLE_W`=24
  - typedef `sample_t` (logic [SAMPLE_W-1:0])
  - enum `wbuf_state_t` {PRIME, RUN}
- Sub-module `sample_fifo`: storage, pointers, `count`, full/empty, and push/pop arbitration including the drop rule. It exports `overflow_evt`.
- Top level holds the FSM, issue logic, last-sample register, output registers and sticky flags.

## Test plan
- Reset: drive `reset`=0 for 2 cycles with random inputs → `write`=0, `data_out`=0, `count`=0, `underrun`=0, `overflow`=0.
- Priming (DEPTH=8, `write_ready`=1): push 10, 20, 30 → `write` stays 0 and `count`=3. Push 40 → RUN; `write`=1 with `data_out`=10 on the next edge.
- Ordering/throughput: after the priming case, hold `write_ready`=1 → `write` pulses every other cycle with 20, 30, 40 and `count` returns to 0.
- Underrun: keep `write_ready`=1 with no pushes → next pulse repeats 40 and `underrun`=1. Then push 50 → the following pulse carries 50.
- Overflow/simultaneous: `write_ready`=0, push 1..9 → `count`=8, `overflow`=1, sample 9 absent from the output sequence. Then raise `write_ready` and push 100 on the same edge as a pop at full → `count` stays 8, 100 is stored, and output order is 1..8 then 100.
- Reset mid-run: assert reset with `count`=5 during RUN → next cycle `count`=0, `write`=0, state PRIME. Subsequent 3 pushes produce no `write`.
